// File: rtl/steamer_wx4_if.sv
// steamer_wx4_if
// Wishbone-style bus bundle between the steamer_wx4 stack processor (master)
// and its memory (slave).
//   adr_o  word address (byte address with the LB lane bits dropped)
//   we_o   write enable
//   cyc_o  bus cycle active; stb_o always follows cyc_o
//   sel_o  byte-lane selects, lane 0 = bits 7:0
//   vda_o  data address valid; vpa_o program address valid
//          (both high marks a literal fetch)
//   dat_o  write data
//   ack_i  cycle termination
//   dat_i  read data
interface steamer_wx4_if #(
  parameter int DW = 16,
  parameter int AW = 16
);
  localparam int LB = $clog2(DW / 8);

  logic [AW-LB-1:0] adr_o;
  logic             we_o;
  logic             cyc_o;
  logic             stb_o;
  logic [DW/8-1:0]  sel_o;
  logic             vda_o;
  logic             vpa_o;
  logic [DW-1:0]    dat_o;
  logic             ack_i;
  logic [DW-1:0]    dat_i;

  modport master (
    output adr_o, we_o, cyc_o, stb_o, sel_o, vda_o, vpa_o, dat_o,
    input  ack_i, dat_i
  );

  modport slave (
    input  adr_o, we_o, cyc_o, stb_o, sel_o, vda_o, vpa_o, dat_o,
    output ack_i, dat_i
  );
endinterface

// File: rtl/steamer_wx4.sv
// steamer_wx4
// Packed-opcode stack processor. Fetches DW-bit instruction words holding
// DW/4 four-bit opcodes and executes them MSB-first against a DEPTH-entry
// register stack (entry 0 = z, 1 = y, 2 = x).
//   clk_i  clock, all state on the rising edge
//   res_i  asynchronous active-high reset; also forces every bus output low
//   bus    steamer_wx4_if master modport (address, data, selects, handshake)
module steamer_wx4 #(
  parameter int DW    = 16,
  parameter int AW    = 16,
  parameter int DEPTH = 3
) (
  input  logic          clk_i,
  input  logic          res_i,
  steamer_wx4_if.master bus
);
  localparam int NB = DW / 8;
  localparam int LB = $clog2(NB);
  localparam int PW = AW - LB;

  typedef enum logic {PH_FETCH, PH_EXEC} phase_t;

  phase_t          r_phase;
  logic [PW-1:0]   r_p;
  logic [DW-1:0]   r_ir;
  logic [DW-1:0]   r_stk [DEPTH];

  logic [3:0]      w_op;
  logic [DW-1:0]   w_z;
  logic [DW-1:0]   w_y;
  logic [PW-1:0]   w_zAdr;
  logic [LB-1:0]   w_lane;
  logic [NB-1:0]   w_laneSel;
  logic [7:0]      w_byte;
  logic            w_restZero;
  logic            w_taken;
  logic            w_adv;
  logic [DW-1:0]   w_pushVal;
  logic [DW-1:0]   w_pop1 [DEPTH];
  logic [DW-1:0]   w_pop2 [DEPTH];
  logic [DW-1:0]   w_pop3 [DEPTH];
  logic [DW-1:0]   w_push [DEPTH];
  logic [DW-1:0]   w_nstk [DEPTH];

  logic            w_cyc;
  logic            w_we;
  logic            w_vda;
  logic            w_vpa;
  logic [PW-1:0]   w_adr;
  logic [NB-1:0]   w_sel;
  logic [DW-1:0]   w_dat;

  assign w_op       = r_ir[DW-1 -: 4];
  assign w_z        = r_stk[0];
  assign w_y        = r_stk[1];
  assign w_zAdr     = w_z[AW-1:LB];
  assign w_lane     = w_z[LB-1:0];
  assign w_laneSel  = NB'(1) << w_lane;
  assign w_byte     = 8'(bus.dat_i >> {w_lane, 3'b000});
  assign w_restZero = (r_ir[DW-5:0] == '0);

  // Stack shift networks. Pops move entries toward the top and duplicate
  // the bottom entry; a push moves entries away and drops the bottom one.
  for (genvar g = 0; g < DEPTH; g++) begin : g_shift
    localparam int J1 = (g + 1 < DEPTH) ? g + 1 : DEPTH - 1;
    localparam int J2 = (g + 2 < DEPTH) ? g + 2 : DEPTH - 1;
    localparam int J3 = (g + 3 < DEPTH) ? g + 3 : DEPTH - 1;
    assign w_pop1[g] = r_stk[J1];
    assign w_pop2[g] = r_stk[J2];
    assign w_pop3[g] = r_stk[J3];
    if (g == 0) begin : g_top
      assign w_push[g] = w_pushVal;
    end else begin : g_rest
      assign w_push[g] = r_stk[g-1];
    end
  end

  // Value pushed by LIT / DUP / OVER.
  always_comb begin
    w_pushVal = w_z;
    case (w_op)
      4'h1:    w_pushVal = bus.dat_i;
      4'hC:    w_pushVal = w_y;
      default: w_pushVal = w_z;
    endcase
  end

  // Branch decision for ZGO / GO / NZGO.
  always_comb begin
    w_taken = 1'b0;
    case (w_op)
      4'h7:    w_taken = (w_y == '0);
      4'hE:    w_taken = 1'b1;
      4'hF:    w_taken = (w_y != '0);
      default: w_taken = 1'b0;
    endcase
  end

  // Stack contents after the current slot executes.
  always_comb begin
    w_nstk = r_stk;
    case (w_op)
      4'h1, 4'h9, 4'hC: w_nstk = w_push;
      4'h2:             w_nstk[0] = bus.dat_i;
      4'h3, 4'hB:       w_nstk = w_pop3;
      4'h4: begin
        w_nstk    = w_pop1;
        w_nstk[0] = w_y + w_z;
      end
      4'h5: begin
        w_nstk    = w_pop1;
        w_nstk[0] = w_y & w_z;
      end
      4'h6: begin
        w_nstk    = w_pop1;
        w_nstk[0] = w_y ^ w_z;
      end
      4'h7, 4'hF:       w_nstk = w_pop2;
      4'h8:             w_nstk[0] = w_z >> 1;
      4'hA:             w_nstk[0] = DW'(w_byte);
      4'hE:             w_nstk = w_pop1;
      default:          w_nstk = r_stk;
    endcase
  end

  // Bus request for the current phase. FETCH and the memory opcodes run a
  // cycle; everything else leaves the bus idle with all fields zero.
  always_comb begin
    w_cyc = 1'b0;
    w_we  = 1'b0;
    w_vda = 1'b0;
    w_vpa = 1'b0;
    w_adr = '0;
    w_sel = '0;
    w_dat = '0;
    if (r_phase == PH_FETCH) begin
      w_cyc = 1'b1;
      w_vpa = 1'b1;
      w_adr = r_p;
      w_sel = '1;
    end else begin
      case (w_op)
        4'h1: begin
          w_cyc = 1'b1;
          w_vda = 1'b1;
          w_vpa = 1'b1;
          w_adr = r_p;
          w_sel = '1;
        end
        4'h2: begin
          w_cyc = 1'b1;
          w_vda = 1'b1;
          w_adr = w_zAdr;
          w_sel = '1;
        end
        4'h3: begin
          w_cyc = 1'b1;
          w_vda = 1'b1;
          w_we  = 1'b1;
          w_adr = w_zAdr;
          w_sel = '1;
          w_dat = w_y;
        end
        4'hA: begin
          w_cyc = 1'b1;
          w_vda = 1'b1;
          w_adr = w_zAdr;
          w_sel = w_laneSel;
        end
        4'hB: begin
          w_cyc = 1'b1;
          w_vda = 1'b1;
          w_we  = 1'b1;
          w_adr = w_zAdr;
          w_sel = w_laneSel;
          w_dat = {NB{w_y[7:0]}};
        end
        default: w_cyc = 1'b0;
      endcase
    end
  end

  // Bus slots stall until ack; ack is ignored when no cycle is running.
  assign w_adv = w_cyc ? bus.ack_i : 1'b1;

  // Reset gates the outputs directly so an in-flight cycle is dropped
  // without waiting for a clock edge.
  assign bus.cyc_o = w_cyc & ~res_i;
  assign bus.stb_o = w_cyc & ~res_i;
  assign bus.we_o  = w_we & ~res_i;
  assign bus.vda_o = w_vda & ~res_i;
  assign bus.vpa_o = w_vpa & ~res_i;
  assign bus.adr_o = res_i ? '0 : w_adr;
  assign bus.sel_o = res_i ? '0 : w_sel;
  assign bus.dat_o = res_i ? '0 : w_dat;

  // Sequencer: fetch a word, then step through its opcodes until the rest
  // of the word is zero or a branch is taken.
  always_ff @(posedge clk_i or posedge res_i) begin
    if (res_i) begin
      r_phase <= PH_FETCH;
      r_p     <= '0;
      r_ir    <= '0;
      for (int i = 0; i < DEPTH; i++) r_stk[i] <= '0;
    end else if (w_adv) begin
      if (r_phase == PH_FETCH) begin
        r_ir    <= bus.dat_i;
        r_p     <= r_p + PW'(1);
        r_phase <= (bus.dat_i == '0) ? PH_FETCH : PH_EXEC;
      end else begin
        r_stk <= w_nstk;
        r_ir  <= r_ir << 4;
        if (w_taken) begin
          r_p     <= w_zAdr;
          r_phase <= PH_FETCH;
        end else begin
          if (w_op == 4'h1) r_p <= r_p + PW'(1);
          if (w_restZero) r_phase <= PH_FETCH;
        end
      end
    end
  end
endmodule

// File: tb/tb_steamer_wx4.sv
// tb_steamer_wx4
// Directed bench for steamer_wx4: a 16-bit / depth-3 core and a 32-bit /
// depth-8 core, each with a small word memory answering its bus.
module tb_steamer_wx4;
  logic clk = 1'b0;
  logic res = 1'b1;
  logic ackEn16 = 1'b1;
  logic ackEn32 = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [15:0] mem16 [256];
  logic [31:0] mem32 [256];

  steamer_wx4_if #(.DW(16), .AW(16)) bus16 ();
  steamer_wx4_if #(.DW(32), .AW(16)) bus32 ();

  steamer_wx4 #(.DW(16), .AW(16), .DEPTH(3)) u16 (
    .clk_i (clk),
    .res_i (res),
    .bus   (bus16)
  );

  steamer_wx4 #(.DW(32), .AW(16), .DEPTH(8)) u32 (
    .clk_i (clk),
    .res_i (res),
    .bus   (bus32)
  );

  always #5 clk = ~clk;

  // Memories answer combinationally; ackEn withholds termination.
  assign bus16.ack_i = bus16.cyc_o & ackEn16;
  assign bus16.dat_i = mem16[bus16.adr_o[7:0]];
  assign bus32.ack_i = bus32.cyc_o & ackEn32;
  assign bus32.dat_i = mem32[bus32.adr_o[7:0]];

  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance n clock cycles and land just after the falling edge.
  task automatic applyStimulus(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic clearMem();
    for (int i = 0; i < 256; i++) begin
      mem16[i] = '0;
      mem32[i] = '0;
    end
  endtask

  // Reset both cores for one cycle and release; leaves them in FETCH at 0.
  task automatic resetDut();
    res = 1'b1;
    ackEn16 = 1'b1;
    ackEn32 = 1'b1;
    applyStimulus(1);
    res = 1'b0;
    #1;
  endtask

  initial begin
    clearMem();
    applyStimulus(2);

    $display("[TB] reset state");
    checkOutput("rst cyc16", 64'(bus16.cyc_o), 64'h0);
    checkOutput("rst adr16", 64'(bus16.adr_o), 64'h0);
    checkOutput("rst sel16", 64'(bus16.sel_o), 64'h0);
    checkOutput("rst vpa16", 64'(bus16.vpa_o), 64'h0);
    checkOutput("rst z16",   64'(u16.r_stk[0]), 64'h0);
    checkOutput("rst cyc32", 64'(bus32.cyc_o), 64'h0);

    $display("[TB] LIT LIT ADD");
    mem16[0] = 16'h1140;
    mem16[1] = 16'h0003;
    mem16[2] = 16'h0004;
    resetDut();
    checkOutput("f0 cyc", 64'(bus16.cyc_o), 64'h1);
    checkOutput("f0 stb", 64'(bus16.stb_o), 64'h1);
    checkOutput("f0 adr", 64'(bus16.adr_o), 64'h0);
    checkOutput("f0 vpa", 64'(bus16.vpa_o), 64'h1);
    checkOutput("f0 vda", 64'(bus16.vda_o), 64'h0);
    checkOutput("f0 sel", 64'(bus16.sel_o), 64'h3);
    applyStimulus(1);
    checkOutput("lit1 adr", 64'(bus16.adr_o), 64'h1);
    checkOutput("lit1 vda", 64'(bus16.vda_o), 64'h1);
    checkOutput("lit1 vpa", 64'(bus16.vpa_o), 64'h1);
    applyStimulus(1);
    checkOutput("lit2 adr", 64'(bus16.adr_o), 64'h2);
    applyStimulus(1);
    checkOutput("add cyc", 64'(bus16.cyc_o), 64'h0);
    checkOutput("add adr", 64'(bus16.adr_o), 64'h0);
    applyStimulus(1);
    checkOutput("f3 adr", 64'(bus16.adr_o), 64'h3);
    checkOutput("f3 cyc", 64'(bus16.cyc_o), 64'h1);
    checkOutput("add z",  64'(u16.r_stk[0]), 64'h7);

    $display("[TB] ZGO taken");
    clearMem();
    mem16[0] = 16'h1170;
    mem16[1] = 16'h0000;
    mem16[2] = 16'h0040;
    resetDut();
    applyStimulus(3);
    checkOutput("zgo cyc", 64'(bus16.cyc_o), 64'h0);
    applyStimulus(1);
    checkOutput("zgo tgt", 64'(bus16.adr_o), 64'h20);
    checkOutput("zgo z",   64'(u16.r_stk[0]), 64'h0);

    $display("[TB] ZGO not taken");
    mem16[1] = 16'h0001;
    resetDut();
    applyStimulus(4);
    checkOutput("zgo nt adr", 64'(bus16.adr_o), 64'h3);

    $display("[TB] NZGO taken");
    mem16[0] = 16'h11F0;
    resetDut();
    applyStimulus(4);
    checkOutput("nzgo tgt", 64'(bus16.adr_o), 64'h20);

    $display("[TB] OVER AND DUP LSR XOR, zero word");
    clearMem();
    mem16[0] = 16'h11C5;
    mem16[1] = 16'h00F0;
    mem16[2] = 16'h003C;
    mem16[3] = 16'h9861;
    mem16[4] = 16'h0005;
    resetDut();
    applyStimulus(5);
    checkOutput("and adr", 64'(bus16.adr_o), 64'h3);
    checkOutput("and z",   64'(u16.r_stk[0]), 64'h30);
    checkOutput("and y",   64'(u16.r_stk[1]), 64'hF0);
    applyStimulus(5);
    checkOutput("xor adr", 64'(bus16.adr_o), 64'h5);
    checkOutput("xor z",   64'(u16.r_stk[0]), 64'h5);
    checkOutput("xor y",   64'(u16.r_stk[1]), 64'h28);
    checkOutput("xor x",   64'(u16.r_stk[2]), 64'hF0);
    applyStimulus(1);
    checkOutput("zero word adr", 64'(bus16.adr_o), 64'h6);

    $display("[TB] FBM");
    clearMem();
    mem16[0] = 16'h1A00;
    mem16[1] = 16'h0011;
    mem16[8] = 16'hBEEF;
    resetDut();
    applyStimulus(2);
    checkOutput("fbm sel", 64'(bus16.sel_o), 64'h2);
    checkOutput("fbm adr", 64'(bus16.adr_o), 64'h8);
    checkOutput("fbm vda", 64'(bus16.vda_o), 64'h1);
    checkOutput("fbm vpa", 64'(bus16.vpa_o), 64'h0);
    checkOutput("fbm we",  64'(bus16.we_o), 64'h0);
    applyStimulus(1);
    checkOutput("fbm z",   64'(u16.r_stk[0]), 64'hBE);
    checkOutput("fbm next", 64'(bus16.adr_o), 64'h2);

    $display("[TB] SBM");
    clearMem();
    mem16[0] = 16'h11B0;
    mem16[1] = 16'h1234;
    mem16[2] = 16'h0011;
    resetDut();
    applyStimulus(3);
    checkOutput("sbm dat", 64'(bus16.dat_o), 64'h3434);
    checkOutput("sbm sel", 64'(bus16.sel_o), 64'h2);
    checkOutput("sbm we",  64'(bus16.we_o), 64'h1);
    checkOutput("sbm adr", 64'(bus16.adr_o), 64'h8);
    applyStimulus(1);
    checkOutput("sbm z",    64'(u16.r_stk[0]), 64'h0);
    checkOutput("sbm next", 64'(bus16.adr_o), 64'h3);

    $display("[TB] FWM wait states");
    clearMem();
    mem16[0] = 16'h1200;
    mem16[1] = 16'h0010;
    mem16[8] = 16'h5A5A;
    resetDut();
    applyStimulus(2);
    ackEn16 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checkOutput("fwm wait adr", 64'(bus16.adr_o), 64'h8);
      checkOutput("fwm wait cyc", 64'(bus16.cyc_o), 64'h1);
      checkOutput("fwm wait z",   64'(u16.r_stk[0]), 64'h10);
      applyStimulus(1);
    end
    ackEn16 = 1'b1;
    #1;
    checkOutput("fwm ack adr", 64'(bus16.adr_o), 64'h8);
    checkOutput("fwm ack z",   64'(u16.r_stk[0]), 64'h10);
    applyStimulus(1);
    checkOutput("fwm z",    64'(u16.r_stk[0]), 64'h5A5A);
    checkOutput("fwm next", 64'(bus16.adr_o), 64'h2);

    $display("[TB] reset during SWM");
    clearMem();
    mem16[0] = 16'h1130;
    mem16[1] = 16'h00AB;
    mem16[2] = 16'h0010;
    resetDut();
    applyStimulus(3);
    checkOutput("swm we",  64'(bus16.we_o), 64'h1);
    checkOutput("swm dat", 64'(bus16.dat_o), 64'hAB);
    checkOutput("swm adr", 64'(bus16.adr_o), 64'h8);
    ackEn16 = 1'b0;
    applyStimulus(1);
    checkOutput("swm hold cyc", 64'(bus16.cyc_o), 64'h1);
    #2;
    res = 1'b1;
    #1;
    checkOutput("midrst cyc", 64'(bus16.cyc_o), 64'h0);
    checkOutput("midrst we",  64'(bus16.we_o), 64'h0);
    checkOutput("midrst adr", 64'(bus16.adr_o), 64'h0);
    checkOutput("midrst dat", 64'(bus16.dat_o), 64'h0);
    checkOutput("midrst sel", 64'(bus16.sel_o), 64'h0);
    checkOutput("midrst vda", 64'(bus16.vda_o), 64'h0);
    checkOutput("midrst z",   64'(u16.r_stk[0]), 64'h0);
    applyStimulus(1);
    ackEn16 = 1'b1;
    res = 1'b0;
    #1;
    checkOutput("post rst cyc", 64'(bus16.cyc_o), 64'h1);
    checkOutput("post rst adr", 64'(bus16.adr_o), 64'h0);

    $display("[TB] DW=32 DEPTH=8");
    clearMem();
    mem32[0] = 32'h11111111;
    for (int i = 1; i <= 8; i++) mem32[i] = 32'(i);
    mem32[9]  = 32'h44400000;
    mem32[10] = 32'h1A000000;
    mem32[11] = 32'h00000083;
    mem32[32] = 32'hC5000000;
    resetDut();
    applyStimulus(9);
    checkOutput("w32 lits adr", 64'(bus32.adr_o), 64'h9);
    checkOutput("w32 lits z",   64'(u32.r_stk[0]), 64'h8);
    checkOutput("w32 lits e7",  64'(u32.r_stk[7]), 64'h1);
    applyStimulus(4);
    checkOutput("w32 add adr", 64'(bus32.adr_o), 64'hA);
    checkOutput("w32 add z",   64'(u32.r_stk[0]), 64'd26);
    checkOutput("w32 add e1",  64'(u32.r_stk[1]), 64'h4);
    checkOutput("w32 add e3",  64'(u32.r_stk[3]), 64'h2);
    checkOutput("w32 add e7",  64'(u32.r_stk[7]), 64'h1);
    applyStimulus(2);
    checkOutput("w32 fbm sel", 64'(bus32.sel_o), 64'h8);
    checkOutput("w32 fbm adr", 64'(bus32.adr_o), 64'h20);
    applyStimulus(1);
    checkOutput("w32 fbm z",    64'(u32.r_stk[0]), 64'hC5);
    checkOutput("w32 fbm next", 64'(bus32.adr_o), 64'hC);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
